// File: rtl/des_key_pkg.sv
// ============================================================================
// des_key_pkg : DES key-schedule tables, FSM state type, PC-1/PC-2 helpers
// Revision    : 1.0
// ============================================================================
`default_nettype none

package des_key_pkg;

   localparam int NUM_ROUNDS = 16;
   localparam int HALF_W     = 28;
   localparam int SUBKEY_W   = 48;
   localparam int KEY_W      = 64;

   localparam logic ROT_LEFT  = 1'b0;
   localparam logic ROT_RIGHT = 1'b1;

   // Table entries are 1-based DES bit numbers (bit 1 = MSB).
   localparam logic [5:0] PC1 [56] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
      6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
      6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
      6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
      6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
      6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
      6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [5:0] PC2 [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
      6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
      6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
      6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
      6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   // SHIFTS[0] holds the shift for round 1.
   localparam logic [1:0] SHIFTS [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [0:55] pc1(input logic [0:KEY_W-1] key);
      logic [0:55] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r[i] = key[PC1[i] - 6'd1];
      end
      return r;
   endfunction

   function automatic logic [0:SUBKEY_W-1] pc2(input logic [0:2*HALF_W-1] cd);
      logic [0:SUBKEY_W-1] r;
      r = '0;
      for (int i = 0; i < SUBKEY_W; i++) begin
         r[i] = cd[PC2[i] - 6'd1];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/des_half_rotate.sv
// ============================================================================
// des_half_rotate : 28-bit combinational rotator, left/right by 1 or 2
// Revision        : 1.0
// ============================================================================
`default_nettype none

module des_half_rotate
   import des_key_pkg::*;
(
   input  logic              i_dir,
   input  logic              i_amt2,
   input  logic [0:HALF_W-1] i_half,
   output logic [0:HALF_W-1] o_half
);

   // Index 0 is the MSB, so "left" moves bits toward index 0.
   always_comb begin
      o_half = i_half;
      case ({i_dir, i_amt2})
         {ROT_LEFT,  1'b0}: o_half = {i_half[1:HALF_W-1], i_half[0]};
         {ROT_LEFT,  1'b1}: o_half = {i_half[2:HALF_W-1], i_half[0:1]};
         {ROT_RIGHT, 1'b0}: o_half = {i_half[HALF_W-1], i_half[0:HALF_W-2]};
         {ROT_RIGHT, 1'b1}: o_half = {i_half[HALF_W-2:HALF_W-1], i_half[0:HALF_W-3]};
         default:           o_half = i_half;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/des_key_schedule_iter.sv
// ============================================================================
// des_key_schedule_iter : iterative DES subkey generator, one subkey per handshake
// Revision              : 1.0
// ============================================================================
`default_nettype none

module des_key_schedule_iter
   import des_key_pkg::*;
#(
   parameter bit DECRYPT = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [0:KEY_W-1]    key_in,
   output logic                busy,
   output logic [0:SUBKEY_W-1] subkey,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [3:0]          subkey_round,
   output logic                done
);

   localparam logic c_dir = DECRYPT ? ROT_RIGHT : ROT_LEFT;

   state_t            r_state;
   logic [0:HALF_W-1] r_c;
   logic [0:HALF_W-1] r_d;
   logic [3:0]        r_count;
   logic              r_busy;
   logic              r_valid;
   logic              r_done;

   logic [0:2*HALF_W-1] w_pc1;
   logic [0:HALF_W-1]   w_c_load;
   logic [0:HALF_W-1]   w_d_load;
   logic [0:HALF_W-1]   w_c_rot;
   logic [0:HALF_W-1]   w_d_rot;
   logic [3:0]          w_shift_idx;
   logic                w_amt2;
   logic                w_accept;

   assign w_pc1 = pc1(key_in);

   // Decrypt starts at C16/D16 which equals C0/D0; encrypt starts at C1/D1.
   assign w_c_load = DECRYPT ? w_pc1[0:HALF_W-1]
                             : {w_pc1[1:HALF_W-1], w_pc1[0]};
   assign w_d_load = DECRYPT ? w_pc1[HALF_W:2*HALF_W-1]
                             : {w_pc1[HALF_W+1:2*HALF_W-1], w_pc1[HALF_W]};

   assign w_shift_idx = DECRYPT ? (4'd15 - r_count) : (r_count + 4'd1);
   assign w_amt2      = (SHIFTS[w_shift_idx] == 2'd2);
   assign w_accept    = r_valid && subkey_ready;

   des_half_rotate u_rot_c (
      .i_dir  (c_dir),
      .i_amt2 (w_amt2),
      .i_half (r_c),
      .o_half (w_c_rot)
   );

   des_half_rotate u_rot_d (
      .i_dir  (c_dir),
      .i_amt2 (w_amt2),
      .i_half (r_d),
      .o_half (w_d_rot)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_c     <= w_c_load;
                  r_d     <= w_d_load;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_state <= EMIT;
               end
            end
            EMIT: begin
               if (w_accept) begin
                  if (r_count == 4'd15) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     // Final right shift by SHIFTS[round 1] returns C/D to PC-1(key).
                     if (DECRYPT) begin
                        r_c <= w_c_rot;
                        r_d <= w_d_rot;
                     end
                  end else begin
                     r_count <= r_count + 4'd1;
                     r_c     <= w_c_rot;
                     r_d     <= w_d_rot;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign subkey_valid = r_valid;
   assign done         = r_done;
   assign subkey       = pc2({r_c, r_d});
   assign subkey_round = !r_valid ? 4'd0 : (DECRYPT ? (4'd15 - r_count) : r_count);

endmodule

`default_nettype wire

// File: doc/des_key_schedule_iter.md
Name: des_key_schedule_iter

Overview:
Iterative DES subkey generator for the decryption datapath. It loads a 64-bit key, applies PC-1, and emits one 48-bit PC-2 subkey per handshake. Decrypt order is K16 down to K1, produced by right-rotating the C/D halves; this is the inverse of the encryption key shifter. A parameter selects encrypt order (K1..K16, left-rotating), so the block can feed either end of the round pipeline.

Parameters:
DECRYPT, 1, 1 = emit K16..K1 using right rotations; 0 = emit K1..K16 using left rotations.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active low
start  input  1  request a new schedule; accepted only when busy=0
key_in  input  [0:63]  DES key, bit 0 = DES bit 1 (MSB); parity bits ignored
busy  output  1  high from the cycle after an accepted start until the last subkey is accepted
subkey  output  [0:47]  current subkey, PC-2 of the C/D registers
subkey_valid  output  1  subkey is valid
subkey_ready  input  1  consumer accepts the subkey when valid && ready
subkey_round  output  4  DES round index minus 1 of the presented subkey (K16 -> 15)
done  output  1  one-cycle pulse in the cycle after the final subkey is accepted

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; C, D and count = 0; busy=0, subkey_valid=0, done=0. subkey_round is 0 and subkey = PC-2(0) = 0.
- Reset mid-schedule aborts immediately. No further subkeys are emitted and no done pulse is produced.
- States:
  - IDLE: start=1 samples key_in. {C,D} <= PC-1(key_in) if DECRYPT, else {rotl1(C0), rotl1(D0)}. count <= 0. Go to EMIT. busy and subkey_valid rise in the next cycle (1-cycle latency).
  - EMIT: subkey_valid=1 and subkey = PC-2({C,D}), combinational from the registers and stable while stalled. On valid&&ready:
    - if count==15: go to DONE.
    - else: count++ and rotate C and D by amt.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A start in DONE is ignored.
- Rotation amount. SHIFTS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: after emitting the subkey for round r=16-count, rotate right by SHIFTS[r]. Amounts in order: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt: after emitting round r=count+1, rotate left by SHIFTS[r+1].
  - C and D are each 28-bit and rotate independently, never across the boundary.
- subkey_round = 15-count (decrypt) or count (encrypt).
- start while busy is ignored, and key_in is not resampled.
- subkey_ready held low stalls the block indefinitely with no state change.
- Back-to-back: ready held high yields 16 subkeys in 16 consecutive cycles. An accepted start takes the first IDLE cycle after DONE.
- After the full schedule, the C/D registers return to PC-1(key) in decrypt mode (total rotation 28 ≡ 0). This is an assertion target.

Decomposition:
- Package des_key_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries);
  - SHIFTS array (16 entries);
  - NUM_ROUNDS=16, HALF_W=28, SUBKEY_W=48;
  - a state enum {IDLE, EMIT, DONE};
  - functions pc1() and pc2().
- One sub-module, des_half_rotate: 28-bit combinational rotator with inputs dir (left/right) and amt2 (0 = by 1, 1 = by 2). It is instantiated twice, once for C and once for D.
- The FSM, counter and handshake live in des_key_schedule_iter.

Test Plan:
1. DECRYPT=1, key 0x133457799BBCDFF1, ready=1 -> first subkey 0xCB3D8B0E17F5 with round=15; last subkey 0x1B02EFFC7072 with round=0; done pulses one cycle after it; 16 valid cycles total.
2. DECRYPT=0, same key -> first subkey 0x1B02EFFC7072 (round 0), last 0xCB3D8B0E17F5 (round 15). The reversed decrypt sequence must match this sequence exactly.
3. Random ready stalls (about 40% low) -> subkey and round are stable while valid&&!ready; the sequence is identical to scenario 1.
4. start pulsed at subkey 5 with a different key -> ignored; the schedule completes with the original key's subkeys.
5. rst_n low for one cycle after subkey 7 -> next cycle valid=0, busy=0, no done pulse. A new start then yields K16 of the new key.
6. Key 0x0000000000000000 then 0xFFFFFFFFFFFFFFFF -> all 16 subkeys are 0, then all 16 are 0xFFFFFFFFFFFF. Checks parity-bit ignore and back-to-back starts.
